sram_word_controller: RTL
=========================

Name: sram_word_controller

Overview:
- Memory-side controller between the pipeline's MEM stage and the board's 16-bit external SRAM (256K x 16).
- Converts one 32-bit load/store into two sequenced halfword SRAM accesses, each with programmable wait states.
- Exposes a ready flag that the hazard unit inverts to produce SRAM_NOT_READY, freezing the pipeline.
- Drives the SRAM pins directly, so SRAM pin behaviour is owned here, not in MEM stage.

Parameters:
- ADDR_BASE, 1024: byte offset subtracted from the CPU address before mapping to SRAM.
- WAIT_CYCLES, 1: extra cycles each halfword phase is held (phase length = WAIT_CYCLES+1); legal range 0..7.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous reset, active-low; sampled on rising edge of clk.
- rd_en  input  1  load request from MEM stage.
- wr_en  input  1  store request from MEM stage.
- address  input  32  byte address (ALU result).
- wdata  input  32  store data.
- rdata  output  32  load data; holds until the next load completes.
- ready  output  1  high = no transaction pending or result valid this cycle.
- SRAMaddress  output  18  SRAM halfword address.
- SRAMWEn  output  1  SRAM write enable, active-low.
- SRAMOE  output  1  SRAM output enable, active-low.
- SRAMdata  inout  16  SRAM data bus; driven only during write phases, else high-Z.

Behaviour:
- Reset (rst=0 at an edge, including mid-transaction):
  - state=IDLE, rdata=0, phase counter=0.
  - SRAMWEn=1, SRAMOE=1, SRAMaddress=0, SRAMdata=Z.
  - Any in-flight access is abandoned with no partial-write cleanup.
- Address map:
  - off = address-ADDR_BASE (32-bit wrap).
  - word = off[18:2]; SRAMaddress = {word[16:0], h}, where h=0 for the low phase and h=1 for the high phase.
  - off[1:0] is ignored (word-aligned only).
- FSM states: IDLE, LO, HI, DONE.
  - IDLE: if wr_en or rd_en, latch op (write has priority when both are high), address and wdata; go to LO. Otherwise stay.
  - LO: hold WAIT_CYCLES+1 cycles, then go to HI.
  - HI: hold WAIT_CYCLES+1 cycles, then go to DONE.
  - DONE: one cycle, then IDLE.
- Requests are latched. Input changes during LO/HI do not affect the transaction. A dropped request still completes.
- Write phases:
  - SRAMWEn=0 for the whole phase, SRAMOE=1.
  - SRAMdata = wdata[15:0] in LO, wdata[31:16] in HI.
- Read phases:
  - SRAMOE=0, SRAMWEn=1, SRAMdata=Z.
  - SRAMdata is sampled on the last cycle of each phase: low half in LO, high half in HI.
  - rdata updates as a whole 32-bit word on entry to DONE.
- ready:
  - ready = (state==DONE) | (state==IDLE & ~rd_en & ~wr_en).
  - It is 0 in the IDLE cycle a request arrives and throughout LO/HI.
- Latency: request first seen in cycle 0 → ready=1 in cycle 2*(WAIT_CYCLES+1)+1 (cycle 5 at default).
- Back-to-back: a request still asserted in the cycle after DONE (IDLE) starts a new transaction. The pipeline must have advanced on the DONE cycle.
- Outside LO/HI: SRAMWEn=1, SRAMOE=1, SRAMdata=Z, SRAMaddress holds its last value.

Test Plan:
- Store then load, WAIT_CYCLES=1: wr_en=1, address=1024, wdata=0xDEADBEEF.
  - SRAM[0]=0xBEEF, SRAM[1]=0xDEAD.
  - ready low in cycles 0-4, high in cycle 5.
  - A following rd_en at 1024 returns rdata=0xDEADBEEF in its DONE cycle.
- Address map: store at address=1032 → SRAMaddress 4 then 5 are written; SRAM[0..3] unchanged.
- Simultaneous requests: rd_en=wr_en=1, address=1028, wdata=0x12345678 → write performed (SRAM[2]=0x5678, SRAM[3]=0x1234); rdata unchanged.
- Request dropped mid-transaction: load with rd_en deasserted in cycle 2 → transaction completes, DONE still occurs in cycle 5, rdata is updated.
- Reset mid-write: rst=0 during HI → next cycle SRAMWEn=1, SRAMOE=1, SRAMdata=Z, ready=1 (no request). SRAM[1] is not written.
- WAIT_CYCLES=0: load → ready high in cycle 3; each phase holds SRAMOE=0 for exactly 1 cycle.

Source files
------------

// File: rtl/sram_word_controller.sv
// Sequences one 32-bit CPU load/store into two halfword accesses
// on a 16-bit asynchronous SRAM, with programmable wait states.
module sram_word_controller #(
    parameter logic [31:0] ADDR_BASE   = 32'd1024,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rd_en,
    input  logic        wr_en,
    input  logic [31:0] address,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic [17:0] SRAMaddress,
    output logic        SRAMWEn,
    output logic        SRAMOE,
    inout  wire  [15:0] SRAMdata
);

    typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

    localparam logic [2:0] LAST = 3'(WAIT_CYCLES);

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        wr_q, wr_d;
    logic [16:0] word_q, word_d;
    logic [31:0] wdata_q, wdata_d;
    logic [15:0] lo_q, lo_d;
    logic [31:0] rdata_q, rdata_d;
    logic [17:0] sa_q, sa_d;

    logic        req;
    logic        phase_end;
    logic        active;
    logic [16:0] req_word;
    logic        drive;
    logic [15:0] dout;

    assign req       = rd_en | wr_en;
    assign phase_end = (cnt_q == LAST);
    assign active    = (state_q == LO) | (state_q == HI);
    assign req_word  = 17'((address - ADDR_BASE) >> 2);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            word_q  <= '0;
            wdata_q <= '0;
            lo_q    <= '0;
            rdata_q <= '0;
            sa_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            word_q  <= word_d;
            wdata_q <= wdata_d;
            lo_q    <= lo_d;
            rdata_q <= rdata_d;
            sa_q    <= sa_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (req) state_d = LO;
            LO:      if (phase_end) state_d = HI;
            HI:      if (phase_end) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Latched request and read capture; inputs are ignored once LO starts.
    always_comb begin
        cnt_d   = (active && !phase_end) ? cnt_q + 3'd1 : 3'd0;
        wr_d    = wr_q;
        word_d  = word_q;
        wdata_d = wdata_q;
        lo_d    = lo_q;
        rdata_d = rdata_q;
        sa_d    = sa_q;
        if (state_q == IDLE && req) begin
            wr_d    = wr_en;
            word_d  = req_word;
            wdata_d = wdata;
            sa_d    = {req_word, 1'b0};
        end
        if (state_q == LO && phase_end) begin
            sa_d = {word_q, 1'b1};
            if (!wr_q) lo_d = SRAMdata;
        end
        if (state_q == HI && phase_end && !wr_q)
            rdata_d = {SRAMdata, lo_q};
    end

    always_comb begin
        SRAMWEn = ~(active & wr_q);
        SRAMOE  = ~(active & ~wr_q);
        ready   = (state_q == DONE) | ((state_q == IDLE) & ~req);
        drive   = active & wr_q;
        dout    = (state_q == HI) ? wdata_q[31:16] : wdata_q[15:0];
    end

    assign SRAMaddress = sa_q;
    assign rdata       = rdata_q;
    assign SRAMdata    = drive ? dout : 16'hzzzz;

endmodule
